pulse_peak_det: RTL and testbench
=================================

PULSE_PEAK_DET -- requirements
Module: pulse_peak_det

Interface
REQ-001 SHALL have parameter DATA_W, default 32: sample and peak width in bits.
REQ-002 SHALL have parameter CNT_W, default 16: pulse-width counter width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2: result buffer entries, a power of two.
REQ-004 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port pulse_in, input, DATA_W bits: unsigned filtered sample from the upstream FIR stage.
REQ-007 SHALL have port pulse_vld, input, 1 bit: pulse_in is valid this cycle; there is no backpressure upstream.
REQ-008 SHALL have port thr_hi, input, DATA_W bits: pulse start threshold.
REQ-009 SHALL have port thr_lo, input, DATA_W bits: pulse end threshold (hysteresis).
REQ-010 SHALL have port min_width, input, CNT_W bits: shortest reportable pulse, in samples.
REQ-011 SHALL have port res_peak, output, DATA_W bits: maximum sample of the reported pulse.
REQ-012 SHALL have port res_width, output, CNT_W bits: length of the reported pulse, in valid samples.
REQ-013 SHALL have port res_vld, output, 1 bit: a result is presented.
REQ-014 SHALL have port res_rdy, input, 1 bit: the consumer accepts the result.
REQ-015 SHALL have port drop_cnt, output, 8 bits: number of results lost to a full buffer; saturates at 255.

Function
REQ-016 SHALL implement FSM states IDLE and IN_PULSE, and only samples with pulse_vld=1 SHALL advance it.
REQ-017 IDLE -> IN_PULSE SHALL occur when pulse_in >= thr_hi; on that transition peak = pulse_in and width = 1.
REQ-018 In IN_PULSE, each valid sample with pulse_in >= thr_lo SHALL set peak = max(peak, pulse_in) and width = width + 1, with width saturating at all-ones.
REQ-019 In IN_PULSE, a valid sample with pulse_in < thr_lo SHALL end the pulse, return the FSM to IDLE, and leave peak and width unchanged by that sample.
REQ-020 A pulse end with width >= min_width SHALL push {peak, width} into the FIFO; a pulse end with width < min_width SHALL be discarded silently.
REQ-021 A pulse-ending sample SHALL NOT also start a new pulse, even if thr_lo > thr_hi.
REQ-022 With an empty FIFO, res_vld SHALL rise on the clock edge after the pulse-ending sample is registered, giving 1-cycle latency.
REQ-023 The output handshake SHALL follow these rules:
- Pop occurs when res_vld and res_rdy are both 1.
- res_peak and res_width SHALL hold stable while res_vld=1 and res_rdy=0.
REQ-024 A push into a full FIFO SHALL be dropped and increment drop_cnt, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-025 Threshold and min_width changes SHALL take effect on the next valid sample.

Reset
REQ-026 rst_n=0 SHALL asynchronously force the following, including in the middle of a pulse, and discard any partial pulse:
- FSM = IDLE.
- FIFO empty.
- res_vld = 0.
- res_peak = 0, res_width = 0.
- drop_cnt = 0.
REQ-027 After rst_n deasserts, the first sample SHALL be evaluated as from IDLE.

Configuration
REQ-028 Macro PULSE_TS_EN, when defined, SHALL add a 32-bit output res_ts with the following behaviour:
- A free-running counter of valid samples, wrapping at 2^32, is captured at pulse start and stored with the result.
- The counter is reset to 0.
- res_ts follows the same handshake and stability rules as res_peak.
REQ-029 Without PULSE_TS_EN, res_ts and the sample counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Directed scenario, basic pulse: thr_hi=100, thr_lo=80, min_width=2, res_rdy=1, samples 50,120,150,90,70 -> one result, peak=150, width=3, res_vld one cycle after the sample 70.
REQ-031 Directed scenario, short pulse: min_width=3, samples 50,120,60 -> no result, drop_cnt=0.
REQ-032 Directed scenario, backpressure: res_rdy=0, three qualifying pulses -> two results held stable, drop_cnt=1; then res_rdy=1 -> both results pop in order.
REQ-033 Directed scenario, reset mid-pulse: samples 120,130, then rst_n low for 1 cycle, then samples 70,60 -> no result, all outputs 0.
REQ-034 Directed scenario, gaps and saturation: pulse_vld toggling with samples held at 200 for 70000 valid samples -> width=65535.
REQ-035 Directed scenario, PULSE_TS_EN defined: pulse starting on valid sample index 5 -> res_ts=5.

Source files
------------

// File: rtl/pulse_peak_det.sv
// Hysteresis pulse detector: tracks peak and width of each pulse and queues results.
// Optional macro PULSE_TS_EN adds a res_ts output with the pulse start sample index.
module pulse_peak_det #(
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pulse_in,
    input  logic              pulse_vld,
    input  logic [DATA_W-1:0] thr_hi,
    input  logic [DATA_W-1:0] thr_lo,
    input  logic [CNT_W-1:0]  min_width,
    output logic [DATA_W-1:0] res_peak,
    output logic [CNT_W-1:0]  res_width,
`ifdef PULSE_TS_EN
    output logic [31:0]       res_ts,
`endif
    output logic              res_vld,
    input  logic              res_rdy,
    output logic [7:0]        drop_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE, IN_PULSE} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   peak_q, peak_d;
    logic [CNT_W-1:0]    width_q, width_d;
    logic                end_pulse;
    logic                start_pulse;

    logic [DATA_W-1:0]   mem_peak_q  [FIFO_DEPTH];
    logic [CNT_W-1:0]    mem_width_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       cnt_q;
    logic [7:0]          drop_q;
    logic                push, pop, full, accept, drop;

`ifdef PULSE_TS_EN
    logic [31:0]         ts_cnt_q;
    logic [31:0]         ts_start_q;
    logic [31:0]         mem_ts_q [FIFO_DEPTH];
`endif

    // Detector next state: only valid samples move the FSM or the trackers.
    always_comb begin
        state_d     = state_q;
        peak_d      = peak_q;
        width_d     = width_q;
        end_pulse   = 1'b0;
        start_pulse = 1'b0;
        if (pulse_vld) begin
            unique case (state_q)
                IDLE: begin
                    if (pulse_in >= thr_hi) begin
                        state_d     = IN_PULSE;
                        peak_d      = pulse_in;
                        width_d     = CNT_W'(1);
                        start_pulse = 1'b1;
                    end
                end
                IN_PULSE: begin
                    if (pulse_in >= thr_lo) begin
                        if (pulse_in > peak_q) peak_d = pulse_in;
                        if (width_q != '1) width_d = width_q + CNT_W'(1);
                    end else begin
                        state_d   = IDLE;
                        end_pulse = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Detector state registers; reset drops any partial pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            peak_q  <= '0;
            width_q <= '0;
        end else begin
            state_q <= state_d;
            peak_q  <= peak_d;
            width_q <= width_d;
        end
    end

    assign full   = (cnt_q == CW'(FIFO_DEPTH));
    assign res_vld = (cnt_q != '0);
    assign pop    = res_vld & res_rdy;
    assign push   = end_pulse && (width_q >= min_width);
    // A pop frees a slot in the same cycle, so a push into a full buffer survives.
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    // Result buffer pointers, occupancy and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            drop_q   <= '0;
        end else begin
            if (accept)
                wr_ptr_q <= (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            if (accept && !pop)
                cnt_q <= cnt_q + CW'(1);
            else if (pop && !accept)
                cnt_q <= cnt_q - CW'(1);
            if (drop && drop_q != 8'hFF)
                drop_q <= drop_q + 8'd1;
        end
    end

    // Result storage; cleared on reset so the outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_peak_q[i]  <= '0;
                mem_width_q[i] <= '0;
            end
        end else if (accept) begin
            mem_peak_q[wr_ptr_q]  <= peak_q;
            mem_width_q[wr_ptr_q] <= width_q;
        end
    end

`ifdef PULSE_TS_EN
    // Valid-sample counter, pulse start capture and per-result timestamp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt_q   <= '0;
            ts_start_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_ts_q[i] <= '0;
        end else begin
            if (pulse_vld) ts_cnt_q <= ts_cnt_q + 32'd1;
            if (start_pulse) ts_start_q <= ts_cnt_q;
            if (accept) mem_ts_q[wr_ptr_q] <= ts_start_q;
        end
    end

    assign res_ts = mem_ts_q[rd_ptr_q];
`endif

    assign res_peak  = mem_peak_q[rd_ptr_q];
    assign res_width = mem_width_q[rd_ptr_q];
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_pulse_peak_det.sv
// Directed bench for pulse_peak_det: vector table plus multi-cycle sequences.
// CNT_W is reduced to 8 so width saturation is reachable in a short run.
module tb_pulse_peak_det;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] pulse_in;
    logic          pulse_vld;
    logic [DW-1:0] thr_hi, thr_lo;
    logic [CW-1:0] min_width;
    logic [DW-1:0] res_peak;
    logic [CW-1:0] res_width;
    logic          res_vld;
    logic          res_rdy;
    logic [7:0]    drop_cnt;
`ifdef PULSE_TS_EN
    logic [31:0]   res_ts;
`endif

    pulse_peak_det #(.DATA_W(DW), .CNT_W(CW), .FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pulse_in  (pulse_in),
        .pulse_vld (pulse_vld),
        .thr_hi    (thr_hi),
        .thr_lo    (thr_lo),
        .min_width (min_width),
        .res_peak  (res_peak),
        .res_width (res_width),
`ifdef PULSE_TS_EN
        .res_ts    (res_ts),
`endif
        .res_vld   (res_vld),
        .res_rdy   (res_rdy),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic [7:0]  mw;
        logic        ev;
        logic [31:0] ep;
        logic [7:0]  ew;
        logic [7:0]  ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [31:0] d,
                                input logic [7:0] mw, input logic ev,
                                input logic [31:0] ep, input logic [7:0] ew);
        vec_t x;
        x.v = v; x.d = d; x.r = 1'b1; x.mw = mw;
        x.ev = ev; x.ep = ep; x.ew = ew; x.ed = 8'd0;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    task automatic chk_out(input string nm, input logic ev, input logic [31:0] ep,
                           input logic [7:0] ew, input logic [7:0] ed);
        chk({nm, ".vld"}, {31'd0, res_vld}, {31'd0, ev});
        if (ev) begin
            chk({nm, ".peak"}, res_peak, ep);
            chk({nm, ".width"}, {24'd0, res_width}, {24'd0, ew});
        end
        chk({nm, ".drop"}, {24'd0, drop_cnt}, {24'd0, ed});
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic r);
        @(negedge clk);
        pulse_vld = v;
        pulse_in  = d;
        res_rdy   = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; pulse_vld = 1'b0; pulse_in = '0; res_rdy = 1'b1;
        thr_hi = 32'd100; thr_lo = 32'd80; min_width = 8'd2;

        // basic pulse, result one cycle after the ending sample
        tbl.push_back(mk(1, 50, 2, 0, 0, 0));
        tbl.push_back(mk(1, 120, 2, 0, 0, 0));
        tbl.push_back(mk(1, 150, 2, 0, 0, 0));
        tbl.push_back(mk(1, 90, 2, 0, 0, 0));
        tbl.push_back(mk(1, 70, 2, 1, 150, 3));
        tbl.push_back(mk(0, 0, 2, 0, 0, 0));
        // between thresholds while idle: no start
        tbl.push_back(mk(1, 90, 2, 0, 0, 0));
        // invalid samples ignored mid-pulse
        tbl.push_back(mk(1, 110, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 130, 2, 0, 0, 0));
        tbl.push_back(mk(0, 5, 2, 0, 0, 0));
        tbl.push_back(mk(1, 60, 2, 1, 130, 2));
        tbl.push_back(mk(0, 0, 2, 0, 0, 0));
        // exact threshold values
        tbl.push_back(mk(1, 100, 2, 0, 0, 0));
        tbl.push_back(mk(1, 80, 2, 0, 0, 0));
        tbl.push_back(mk(1, 79, 2, 1, 100, 2));
        tbl.push_back(mk(0, 0, 2, 0, 0, 0));
        // short pulse discarded
        tbl.push_back(mk(1, 50, 3, 0, 0, 0));
        tbl.push_back(mk(1, 120, 3, 0, 0, 0));
        tbl.push_back(mk(1, 60, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3, 0, 0, 0));
        // width equal to min_width is reported
        tbl.push_back(mk(1, 120, 3, 0, 0, 0));
        tbl.push_back(mk(1, 110, 3, 0, 0, 0));
        tbl.push_back(mk(1, 130, 3, 0, 0, 0));
        tbl.push_back(mk(1, 10, 3, 1, 130, 3));
        tbl.push_back(mk(0, 0, 3, 0, 0, 0));

        @(negedge clk);
        @(negedge clk);
        #1;
        chk_out("reset", 1'b0, 0, 0, 8'd0);
        chk("reset.peak0", res_peak, 32'd0);
        chk("reset.width0", {24'd0, res_width}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            min_width = tbl[i].mw;
            step(tbl[i].v, tbl[i].d, tbl[i].r);
            chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ep, tbl[i].ew, tbl[i].ed);
        end

        // backpressure: two held, third dropped, push on full with pop accepted
        min_width = 8'd1;
        step(1, 120, 0); step(1, 70, 0);
        chk_out("bp.a", 1, 120, 1, 0);
        step(1, 200, 0); step(1, 150, 0); step(1, 70, 0);
        chk_out("bp.b_hold", 1, 120, 1, 0);
        step(1, 130, 0); step(1, 70, 0);
        chk_out("bp.c_drop", 1, 120, 1, 1);
        step(0, 0, 0);
        chk_out("bp.stable", 1, 120, 1, 1);
        step(1, 140, 0); step(1, 70, 1);
        chk_out("bp.pop_push", 1, 200, 2, 1);
        step(0, 0, 1);
        chk_out("bp.d", 1, 140, 1, 1);
        step(0, 0, 1);
        chk_out("bp.empty", 0, 0, 0, 1);

        // reset mid-pulse with a pending result and nonzero drop count
        step(1, 120, 0); step(1, 70, 0);
        step(1, 120, 0); step(1, 130, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_out("rst.async", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        min_width = 8'd2;
        step(1, 70, 1); step(1, 60, 1);
        chk_out("rst.after", 0, 0, 0, 0);
        chk("rst.peak0", res_peak, 32'd0);
        chk("rst.width0", {24'd0, res_width}, 32'd0);

        // pulse starting on valid sample index 5 since reset
        min_width = 8'd1;
        step(1, 10, 1); step(0, 0, 1); step(1, 20, 1); step(1, 30, 1);
        step(1, 120, 1); step(1, 70, 1);
        chk_out("ts.res", 1, 120, 1, 0);
`ifdef PULSE_TS_EN
        chk("ts.value", res_ts, 32'd5);
`endif
        step(0, 0, 1);
        chk_out("ts.pop", 0, 0, 0, 0);

        // ending sample must not restart when thr_lo > thr_hi
        thr_lo = 32'd150;
        step(1, 120, 1);
        chk_out("inv.start", 0, 0, 0, 0);
        step(1, 120, 1);
        chk_out("inv.end", 1, 120, 1, 0);
        step(1, 60, 1);
        chk_out("inv.norestart", 0, 0, 0, 0);
        thr_lo = 32'd80;

        // width saturation with gaps
        for (int i = 0; i < 300; i++) begin
            step(1, 200, 1);
            step(0, 0, 1);
        end
        chk_out("sat.mid", 0, 0, 0, 0);
        step(1, 0, 1);
        chk_out("sat.res", 1, 200, 8'd255, 0);
        step(0, 0, 1);
        chk_out("sat.pop", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
